ts_qracc_seq: RTL and testbench

Parametrised, cycle-accurate digital model of the QR accelerator compute macro. It replaces the purely combinational column model with a sequenced precharge/evaluate/convert flow, a registered SRAM read path, selectable binary/bipolar MAC mode, a parameter-driven ADC range shift, and per-column saturation flags. The block sits between the tile controller and the output accumulator, where the RTL testbench uses it in place of the analog macro.

---
 rtl/ts_qracc_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_ts_qracc_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_qracc_seq.sv
// ts_qracc_seq -- sequenced, cycle-accurate model of the QR accelerator compute macro.
//
// The macro holds an SRAM array. It runs a precharge / evaluate / convert flow that
// turns the row drive pattern and the stored weights into one signed bit-line value
// (MBL) per column. Each MBL is then quantised by a range-shifted, saturating ADC
// and also presented as a thermometer code.
//
// Ports
//   CLK, RST             clock (rising edge), asynchronous active-high reset
//   wr_en/wr_row/wr_data write one row; accepted only while idle
//   wr_drop              one-cycle pulse when a write arrives while busy
//   rd_en/rd_row         read request, accepted in any state
//   rd_data/rd_valid     registered read word, with a one-cycle valid pulse
//   mac_start/mac_mode   start a MAC (0 = binary, 1 = bipolar weights)
//   vdr_sel/vss_sel      per-row drive to VDR / VSS, captured at start
//   busy                 high whenever the sequencer is not idle
//   mac_done             one-cycle pulse while the new ADC results are presented
//   adc_code             signed code per column, column j at [j*numAdcBits +: numAdcBits]
//   comp_out             thermometer code per column, column j at [j*compCount +: compCount]
//   sat_hi/sat_lo        per-column clip flags
module ts_qracc_seq #(
  parameter int numRows     = 128,
  parameter int numCols     = 32,
  parameter int numAdcBits  = 4,
  parameter int rangeShifts = 2,
  parameter int adcLatency  = 2,
  localparam int compCount  = 2**numAdcBits - 1,
  localparam int rowW       = $clog2(numRows),
  localparam int mblW       = $clog2(numRows) + 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wr_en,
  input  logic [rowW-1:0]               wr_row,
  input  logic [numCols-1:0]            wr_data,
  output logic                          wr_drop,
  input  logic                          rd_en,
  input  logic [rowW-1:0]               rd_row,
  output logic [numCols-1:0]            rd_data,
  output logic                          rd_valid,
  input  logic                          mac_start,
  input  logic                          mac_mode,
  input  logic [numRows-1:0]            vdr_sel,
  input  logic [numRows-1:0]            vss_sel,
  output logic                          busy,
  output logic                          mac_done,
  output logic [numCols*numAdcBits-1:0] adc_code,
  output logic [numCols*compCount-1:0]  comp_out,
  output logic [numCols-1:0]            sat_hi,
  output logic [numCols-1:0]            sat_lo
);

  localparam int HALF    = 2**(numAdcBits-1);
  localparam int ADC_MAX = HALF - 1;
  localparam int ADC_MIN = -HALF;
  localparam int CNT_W   = (adcLatency > 1) ? $clog2(adcLatency) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(adcLatency - 1);
  // Thermometer pattern of code 0: the low HALF comparators are tripped.
  localparam logic [compCount-1:0] THERM0 = {{(compCount-HALF){1'b0}}, {HALF{1'b1}}};
  localparam logic signed [mblW-1:0] ONE = mblW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PCH,
    S_EVAL,
    S_CONV,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                         hi;
    logic                         lo;
    logic signed [numAdcBits-1:0] code;
  } adc_t;

  // Contribution of one cell to its bit line when the row is driven to VDR.
  // A VSS-driven row contributes the negative of this.
  function automatic logic signed [mblW-1:0] cell_term(input logic bipolar, input logic w);
    logic signed [mblW-1:0] t;
    if (w)
      t = ONE;
    else if (bipolar)
      t = -ONE;
    else
      t = '0;
    return t;
  endfunction

  // Range shift (arithmetic, so it floors) followed by clipping to the ADC range.
  function automatic adc_t adc_quant(input logic signed [mblW-1:0] mbl);
    adc_t r;
    int   s;
    s    = int'(mbl) >>> rangeShifts;
    r.hi = 1'b0;
    r.lo = 1'b0;
    if (s > ADC_MAX) begin
      r.hi   = 1'b1;
      r.code = numAdcBits'(ADC_MAX);
    end else if (s < ADC_MIN) begin
      r.lo   = 1'b1;
      r.code = numAdcBits'(ADC_MIN);
    end else begin
      r.code = numAdcBits'(s);
    end
    return r;
  endfunction

  // Comparator i trips when code + HALF > i, so the count of ones is code + HALF.
  function automatic logic [compCount-1:0] therm(input logic signed [numAdcBits-1:0] code);
    logic [compCount-1:0] t;
    for (int i = 0; i < compCount; i++)
      t[i] = (int'(code) + HALF) > i;
    return t;
  endfunction

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    start_ok;
  logic                    conv_end;

  logic [numCols-1:0]      mem [numRows];

  logic [numRows-1:0]      vdr_p0;
  logic [numRows-1:0]      vss_p0;
  logic                    mode_p0;

  logic signed [mblW-1:0]  acc;
  logic signed [mblW-1:0]  mbl_p0 [numCols];
  logic signed [mblW-1:0]  mbl_p1 [numCols];
  adc_t                    q_p1   [numCols];

  // A start is taken in IDLE and also on the edge that leaves DONE, so that
  // back-to-back operations turn around in 3+adcLatency cycles.
  assign start_ok = mac_start && ((state == S_IDLE) || (state == S_DONE));
  assign conv_end = (state == S_CONV) && (cnt == CNT_LAST);
  assign busy     = (state != S_IDLE);
  assign mac_done = (state == S_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_PCH;
      S_PCH:   state_nxt = S_EVAL;
      S_EVAL:  state_nxt = S_CONV;
      S_CONV:  if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = start_ok ? S_PCH : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (state == S_EVAL)
      cnt <= '0;
    else if (state == S_CONV)
      cnt <= cnt + CNT_W'(1);
  end

  // ---- stage p0: drive pattern and mode captured when a start is accepted
  always_ff @(posedge CLK) begin
    if (start_ok) begin
      vdr_p0  <= vdr_sel;
      vss_p0  <= vss_sel;
      mode_p0 <= mac_mode;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en && (state == S_IDLE))
      mem[wr_row] <= wr_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_drop  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_drop  <= wr_en && (state != S_IDLE);
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= mem[rd_row];
    end
  end

  // Bit-line evaluation. Rows driven to both rails (or neither) add nothing.
  always_comb begin
    acc = '0;
    for (int j = 0; j < numCols; j++) begin
      acc = '0;
      for (int i = 0; i < numRows; i++) begin
        if (vdr_p0[i] && !vss_p0[i])
          acc = acc + cell_term(mode_p0, mem[i][j]);
        else if (vss_p0[i] && !vdr_p0[i])
          acc = acc - cell_term(mode_p0, mem[i][j]);
      end
      mbl_p0[j] = acc;
    end
  end

  // ---- stage p1: MBL registered at the end of EVAL, held through CONV
  always_ff @(posedge CLK) begin
    if (state == S_EVAL)
      mbl_p1 <= mbl_p0;
  end

  always_comb begin
    for (int j = 0; j < numCols; j++)
      q_p1[j] = adc_quant(mbl_p1[j]);
  end

  // ---- stage p2: ADC results presented on entry to DONE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      adc_code <= '0;
      comp_out <= {numCols{THERM0}};
      sat_hi   <= '0;
      sat_lo   <= '0;
    end else if (conv_end) begin
      for (int j = 0; j < numCols; j++) begin
        adc_code[j*numAdcBits +: numAdcBits] <= q_p1[j].code;
        comp_out[j*compCount +: compCount]   <= therm(q_p1[j].code);
        sat_hi[j]                            <= q_p1[j].hi;
        sat_lo[j]                            <= q_p1[j].lo;
      end
    end
  end

endmodule

// File: tb/tb_ts_qracc_seq.sv
module tb_ts_qracc_seq;
  localparam int NR   = 128;
  localparam int NC   = 32;
  localparam int NB   = 4;
  localparam int RS   = 2;
  localparam int CC   = 15;
  localparam int HB   = 8;
  localparam int NR2  = 16;
  localparam int NC2  = 4;
  localparam int NB2  = 3;
  localparam int CC2  = 7;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic              wr_en, rd_en, mac_start, mac_mode;
  logic [6:0]        wr_row, rd_row;
  logic [NC-1:0]     wr_data;
  logic              wr_drop, rd_valid, busy, mac_done;
  logic [NC-1:0]     rd_data, sat_hi, sat_lo;
  logic [NR-1:0]     vdr_sel, vss_sel;
  logic [NC*NB-1:0]  adc_code;
  logic [NC*CC-1:0]  comp_out;

  logic              wr_en2, rd_en2, mac_start2, mac_mode2;
  logic [3:0]        wr_row2, rd_row2;
  logic [NC2-1:0]    wr_data2, rd_data2, sat_hi2, sat_lo2;
  logic              wr_drop2, rd_valid2, busy2, mac_done2;
  logic [NR2-1:0]    vdr2, vss2;
  logic [NC2*NB2-1:0] adc2;
  logic [NC2*CC2-1:0] comp2;

  int checks = 0;
  int errors = 0;
  logic [NC-1:0] mdl_mem [NR];

  ts_qracc_seq dut (
    .CLK(CLK), .RST(RST),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .wr_drop(wr_drop),
    .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data), .rd_valid(rd_valid),
    .mac_start(mac_start), .mac_mode(mac_mode), .vdr_sel(vdr_sel), .vss_sel(vss_sel),
    .busy(busy), .mac_done(mac_done), .adc_code(adc_code), .comp_out(comp_out),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  ts_qracc_seq #(.numRows(NR2), .numCols(NC2), .numAdcBits(NB2), .rangeShifts(0), .adcLatency(2)) dut2 (
    .CLK(CLK), .RST(RST),
    .wr_en(wr_en2), .wr_row(wr_row2), .wr_data(wr_data2), .wr_drop(wr_drop2),
    .rd_en(rd_en2), .rd_row(rd_row2), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .mac_start(mac_start2), .mac_mode(mac_mode2), .vdr_sel(vdr2), .vss_sel(vss2),
    .busy(busy2), .mac_done(mac_done2), .adc_code(adc2), .comp_out(comp2),
    .sat_hi(sat_hi2), .sat_lo(sat_lo2)
  );

  typedef struct {
    logic [NC-1:0] fill;
    int            nfill;
    logic [NR-1:0] vdr;
    logic [NR-1:0] vss;
    logic          mode;
    logic [NB-1:0] code;
    logic          hi;
    logic          lo;
    logic [CC-1:0] th;
  } vec_t;

  vec_t vt [6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wr_word(input int row, input logic [NC-1:0] data);
    wr_en   = 1'b1;
    wr_row  = 7'(row);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
    mdl_mem[row] = data;
  endtask

  task automatic fill_mem(input logic [NC-1:0] word, input int nfill);
    for (int r = 0; r < NR; r++)
      wr_word(r, (r < nfill) ? word : '0);
  endtask

  // Waits (bounded) for mac_done; k0 is the number of edges already seen since the start edge.
  task automatic wait_done(input int k0, output int lat);
    lat = -1;
    for (int k = k0 + 1; k <= 30; k++) begin
      tick();
      if (mac_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_mac(input logic mode, input logic [NR-1:0] vdr, input logic [NR-1:0] vss, output int lat);
    mac_mode  = mode;
    vdr_sel   = vdr;
    vss_sel   = vss;
    mac_start = 1'b1;
    tick();
    mac_start = 1'b0;
    wait_done(0, lat);
  endtask

  // Reference: plain integer bit-line sum, floor division by 2^RS, clip, ones-count thermometer.
  task automatic model(input logic mode, input logic [NR-1:0] vdr, input logic [NR-1:0] vss,
                       output logic [NC*NB-1:0] ecode, output logic [NC*CC-1:0] eth,
                       output logic [NC-1:0] ehi, output logic [NC-1:0] elo);
    int mbl, s, code, d, c;
    d = 1 << RS;
    for (int j = 0; j < NC; j++) begin
      mbl = 0;
      for (int i = 0; i < NR; i++) begin
        if (vdr[i] != vss[i]) begin
          if (mdl_mem[i][j]) c = 1;
          else c = mode ? -1 : 0;
          mbl += vdr[i] ? c : -c;
        end
      end
      if (mbl >= 0) s = mbl / d;
      else s = -((-mbl + d - 1) / d);
      ehi[j] = (s > HB - 1);
      elo[j] = (s < -HB);
      code = ehi[j] ? HB - 1 : (elo[j] ? -HB : s);
      ecode[j*NB +: NB] = code[NB-1:0];
      eth[j*CC +: CC] = CC'((1 << (code + HB)) - 1);
    end
  endtask

  task automatic cmp_model(input string tag, input logic mode, input logic [NR-1:0] vdr, input logic [NR-1:0] vss);
    logic [NC*NB-1:0] ec;
    logic [NC*CC-1:0] et;
    logic [NC-1:0]    eh, el;
    model(mode, vdr, vss, ec, et, eh, el);
    chk({tag, "_code"}, adc_code, ec);
    chk({tag, "_therm"}, comp_out, et);
    chk({tag, "_sathi"}, sat_hi, eh);
    chk({tag, "_satlo"}, sat_lo, el);
  endtask

  initial begin
    int lat, seen;
    logic [NR-1:0] p, q;
    logic m;

    vt[0] = '{32'hFFFF_FFFF, 128, {NR{1'b1}}, '0, 1'b1, 4'h7, 1'b1, 1'b0, 15'h7FFF};
    vt[1] = '{32'h0000_0000, 128, NR'(32'h1F), '0, 1'b1, 4'hE, 1'b0, 1'b0, 15'h003F};
    vt[2] = '{32'hFFFF_FFFF, 128, '0, {NR{1'b1}}, 1'b0, 4'h8, 1'b0, 1'b1, 15'h0000};
    vt[3] = '{32'h0000_0000, 128, '0, NR'(32'hFFFF), 1'b1, 4'h4, 1'b0, 1'b0, 15'h0FFF};
    vt[4] = '{32'hFFFF_FFFF, 8, NR'(32'hFF), NR'(32'hF0), 1'b0, 4'h1, 1'b0, 1'b0, 15'h01FF};
    vt[5] = '{32'hFFFF_FFFF, 8, NR'(32'hFF), NR'(32'hFF), 1'b0, 4'h0, 1'b0, 1'b0, 15'h00FF};

    RST = 1'b1;
    wr_en = 0; rd_en = 0; mac_start = 0; mac_mode = 0;
    wr_row = '0; rd_row = '0; wr_data = '0; vdr_sel = '0; vss_sel = '0;
    wr_en2 = 0; rd_en2 = 0; mac_start2 = 0; mac_mode2 = 0;
    wr_row2 = '0; rd_row2 = '0; wr_data2 = '0; vdr2 = '0; vss2 = '0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", mac_done, 1'b0);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_wrdrop", wr_drop, 1'b0);
    chk("rst_rddata", rd_data, '0);
    chk("rst_code", adc_code, '0);
    chk("rst_sat", {sat_hi, sat_lo}, '0);
    chk("rst_therm", comp_out, {NC{15'h00FF}});
    chk("rst_therm2", comp2, {NC2{7'h0F}});
    RST = 1'b0;
    tick();

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      fill_mem(vt[v].fill, vt[v].nfill);
      run_mac(vt[v].mode, vt[v].vdr, vt[v].vss, lat);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_code", v), adc_code, {NC{vt[v].code}});
      chk($sformatf("vec%0d_therm", v), comp_out, {NC{vt[v].th}});
      chk($sformatf("vec%0d_sathi", v), sat_hi, {NC{vt[v].hi}});
      chk($sformatf("vec%0d_satlo", v), sat_lo, {NC{vt[v].lo}});
      tick();
    end

    // Read/write behaviour.
    wr_word(5, 32'hA5A5_A5A5);
    rd_en = 1'b1; rd_row = 7'd5;
    tick();
    rd_en = 1'b0;
    chk("rd_valid_pulse", rd_valid, 1'b1);
    chk("rd_new_data", rd_data, 32'hA5A5_A5A5);
    tick();
    chk("rd_valid_low", rd_valid, 1'b0);
    chk("rd_data_hold", rd_data, 32'hA5A5_A5A5);
    wr_en = 1'b1; wr_row = 7'd5; wr_data = 32'h1234_5678;
    rd_en = 1'b1; rd_row = 7'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    mdl_mem[5] = 32'h1234_5678;
    chk("rd_same_edge_old", rd_data, 32'hA5A5_A5A5);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("rd_after_write", rd_data, 32'h1234_5678);

    // Write while busy is dropped; selects changed mid-flight are ignored.
    p = {$urandom, $urandom, $urandom, $urandom};
    q = {$urandom, $urandom, $urandom, $urandom};
    mac_mode = 1'b1; vdr_sel = p; vss_sel = q; mac_start = 1'b1;
    tick();
    mac_start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    wr_en = 1'b1; wr_row = 7'd5; wr_data = '0;
    tick();
    wr_en = 1'b0;
    chk("wr_drop_pulse", wr_drop, 1'b1);
    tick();
    chk("wr_drop_clear", wr_drop, 1'b0);
    vdr_sel = ~p; vss_sel = ~q; mac_mode = 1'b0;
    wait_done(2, lat);
    chk("conflict_latency", 32'(lat), 32'd4);
    cmp_model("conflict", 1'b1, p, q);
    tick();
    chk("busy_after_done", busy, 1'b0);
    rd_en = 1'b1; rd_row = 7'd5;
    tick();
    rd_en = 1'b0;
    chk("rd_after_drop", rd_data, 32'h1234_5678);

    // Back-to-back: a start presented during DONE is taken on the edge leaving DONE.
    run_mac(1'b1, q, p, lat);
    chk("b2b_first_latency", 32'(lat), 32'd4);
    cmp_model("b2b_first", 1'b1, q, p);
    mac_mode = 1'b0; vdr_sel = {NR{1'b1}}; vss_sel = '0; mac_start = 1'b1;
    tick();
    mac_start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    wait_done(0, lat);
    chk("b2b_second_latency", 32'(lat), 32'd4);
    cmp_model("b2b_second", 1'b0, {NR{1'b1}}, '0);
    tick();

    // Reset in the middle of CONV.
    mac_mode = 1'b1; vdr_sel = {NR{1'b1}}; vss_sel = '0; mac_start = 1'b1;
    tick();
    mac_start = 1'b0;
    tick();
    tick();
    tick();
    RST = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", mac_done, 1'b0);
    chk("midrst_code", adc_code, '0);
    chk("midrst_therm", comp_out, {NC{15'h00FF}});
    chk("midrst_sat", {sat_hi, sat_lo}, '0);
    chk("midrst_rd", {rd_data, rd_valid}, '0);
    tick();
    RST = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mac_done || busy) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    rd_en = 1'b1; rd_row = 7'd5;
    tick();
    rd_en = 1'b0;
    chk("midrst_mem_kept", rd_data, mdl_mem[5]);

    // Randomised operations against the reference model.
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 16; w++)
        wr_word($urandom_range(0, NR - 1), (it % 2 == 1) ? ($urandom | $urandom) : $urandom);
      m = 1'(it >> 1);
      if (it % 2 == 1) begin
        p = {$urandom | $urandom, $urandom | $urandom, $urandom | $urandom, $urandom | $urandom};
        q = {$urandom & $urandom, $urandom & $urandom, $urandom & $urandom, $urandom & $urandom};
      end else begin
        p = {$urandom, $urandom, $urandom, $urandom};
        q = {$urandom, $urandom, $urandom, $urandom};
      end
      run_mac(m, p, q, lat);
      chk($sformatf("rand%0d_latency", it), 32'(lat), 32'd4);
      cmp_model($sformatf("rand%0d", it), m, p, q);
      tick();
    end

    // Parameter variant: 3-bit ADC, no range shift, 16 rows.
    for (int r = 0; r < NR2; r++) begin
      wr_en2 = 1'b1; wr_row2 = 4'(r); wr_data2 = '0;
      tick();
    end
    wr_en2 = 1'b0;
    mac_mode2 = 1'b1; vdr2 = 16'h01FF; vss2 = '0; mac_start2 = 1'b1;
    tick();
    mac_start2 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (mac_done2) begin lat = k; break; end
    end
    chk("sweep_neg_latency", 32'(lat), 32'd4);
    chk("sweep_neg_code", adc2, {NC2{3'b100}});
    chk("sweep_neg_satlo", sat_lo2, {NC2{1'b1}});
    chk("sweep_neg_sathi", sat_hi2, '0);
    chk("sweep_neg_therm", comp2, '0);
    tick();
    for (int r = 0; r < 3; r++) begin
      wr_en2 = 1'b1; wr_row2 = 4'(r); wr_data2 = 4'hF;
      tick();
    end
    wr_en2 = 1'b0;
    mac_mode2 = 1'b0; vdr2 = 16'h0007; vss2 = '0; mac_start2 = 1'b1;
    tick();
    mac_start2 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (mac_done2) begin lat = k; break; end
    end
    chk("sweep_pos_latency", 32'(lat), 32'd4);
    chk("sweep_pos_code", adc2, {NC2{3'b011}});
    chk("sweep_pos_therm", comp2, {NC2{7'h7F}});
    chk("sweep_pos_sat", {sat_hi2, sat_lo2}, '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
